// File: rtl/placement_eval.sv
// Wirelength evaluator: walks the edge-list ROMs, fetches both endpoint positions
// and accumulates Manhattan length, half-length (1-hop) length and the longest edge.
module placement_eval #(
  parameter int N_EDGE = 96,
  parameter int W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ea_re,
  output logic                eb_re,
  output logic [W-1:0]        ea_addr,
  output logic [W-1:0]        eb_addr,
  input  logic [W-1:0]        ea_data,
  input  logic [W-1:0]        eb_data,
  output logic                px_re,
  output logic                py_re,
  output logic [W-1:0]        px_addr,
  output logic [W-1:0]        py_addr,
  input  logic signed [W-1:0] px_data,
  input  logic signed [W-1:0] py_data,
  output logic signed [W-1:0] sum,
  output logic signed [W-1:0] sum_1hop,
  output logic [W-1:0]        max_len,
  output logic                unplaced
);

  typedef enum logic [2:0] {
    IDLE, FETCH_E, LOAD_E, LOAD_A, LOAD_B, ACC, DONE
  } state_t;

  localparam logic [W-1:0] LAST = W'((N_EDGE > 0) ? N_EDGE - 1 : 0);
  localparam logic [W-1:0] ONE  = W'(1);

  state_t              state;
  logic [W-1:0]        i;
  logic [W-1:0]        node_a, node_b;
  logic signed [W-1:0] xa, ya, xb, yb;

  logic signed [W-1:0] diff_x, diff_y;
  logic [W-1:0]        dx, dy, len, hop;
  logic                edge_unplaced;

  // NOTE: always_comb assigns every signal on every path; a missing assignment
  // would infer a latch.
  always_comb begin
    diff_x        = xa - xb;
    diff_y        = ya - yb;
    dx            = diff_x[W-1] ? -diff_x : diff_x;
    dy            = diff_y[W-1] ? -diff_y : diff_y;
    len           = dx + dy;
    hop           = (dx >> 1) + {{(W-1){1'b0}}, dx[0]}
                  + (dy >> 1) + {{(W-1){1'b0}}, dy[0]} - ONE;
    edge_unplaced = (xa == '1) || (ya == '1) || (xb == '1) || (yb == '1);
  end

  // The position address must follow ea_data in the same cycle it becomes valid,
  // so the strobes and addresses are decoded straight from the state.
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign ea_re   = (state == FETCH_E);
  assign eb_re   = (state == FETCH_E);
  assign ea_addr = i;
  assign eb_addr = i;
  assign px_re   = (state == LOAD_E) || (state == LOAD_A);
  assign py_re   = px_re;
  assign px_addr = (state == LOAD_E) ? ea_data : node_b;
  assign py_addr = px_addr;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register, including the captured operands, is cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i        <= '0;
      node_a   <= '0;
      node_b   <= '0;
      xa       <= '0;
      ya       <= '0;
      xb       <= '0;
      yb       <= '0;
      sum      <= '0;
      sum_1hop <= '0;
      max_len  <= '0;
      unplaced <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i        <= '0;
            sum      <= '0;
            sum_1hop <= '0;
            max_len  <= '0;
            unplaced <= 1'b0;
            state    <= (N_EDGE == 0) ? DONE : FETCH_E;
          end
        end
        FETCH_E: state <= LOAD_E;
        LOAD_E: begin
          node_a <= ea_data;
          node_b <= eb_data;
          state  <= LOAD_A;
        end
        LOAD_A: begin
          xa    <= px_data;
          ya    <= py_data;
          state <= LOAD_B;
        end
        LOAD_B: begin
          xb    <= px_data;
          yb    <= py_data;
          state <= ACC;
        end
        ACC: begin
          if (edge_unplaced) begin
            unplaced <= 1'b1;
          end else begin
            sum      <= sum + $signed(len - ONE);
            sum_1hop <= sum_1hop + $signed(hop);
            if (len > max_len) max_len <= len;
          end
          if (i == LAST) begin
            state <= DONE;
          end else begin
            i     <= i + ONE;
            state <= FETCH_E;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/placement_eval.md
PLACEMENT_EVAL -- requirements
Module: placement_eval

Interface
REQ-001 SHALL have parameter N_EDGE, default 96, number of edges in the edge-list ROMs.
REQ-002 SHALL have parameter W, default 32, width of addresses, data and accumulators.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to evaluate the current placement.
REQ-006 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse when results are final.
REQ-008 SHALL have ports ea_re, eb_re  output  1  read strobes to the edge source/sink ROMs.
REQ-009 SHALL have ports ea_addr, eb_addr  output  W  edge index.
REQ-010 SHALL have ports ea_data, eb_data  input  W  node ids; valid the cycle after the strobe.
REQ-011 SHALL have ports px_re, py_re  output  1  read strobes to the position-X/Y RAMs.
REQ-012 SHALL have ports px_addr, py_addr  output  W  node id.
REQ-013 SHALL have ports px_data, py_data  input  W signed  coordinates; valid the cycle after the strobe; -1 means unplaced.
REQ-014 SHALL have port sum  output  W signed  total of (|dx|+|dy|-1) over placed edges.
REQ-015 SHALL have port sum_1hop  output  W signed  total of (ceil(|dx|/2)+ceil(|dy|/2)-1) over placed edges.
REQ-016 SHALL have port max_len  output  W  largest |dx|+|dy| seen.
REQ-017 SHALL have port unplaced  output  1  sticky flag: some edge endpoint had coordinate -1.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH_E, LOAD_E, LOAD_A, LOAD_B, ACC, DONE.
REQ-019 SHALL, in IDLE with start=1, clear sum, sum_1hop, max_len, unplaced and edge index i, then go to FETCH_E; if N_EDGE=0, go to DONE.
REQ-020 SHALL ignore start in every state other than IDLE.
REQ-021 SHALL, in FETCH_E, pulse ea_re and eb_re with both addresses equal to i.
REQ-022 SHALL, in LOAD_E, capture ea_data as node a and eb_data as node b, and pulse px_re and py_re with address a.
REQ-023 SHALL, in LOAD_A, capture xa and ya, and pulse px_re and py_re with address b.
REQ-024 SHALL, in LOAD_B, capture xb and yb.
REQ-025 SHALL, in ACC, handle an edge with any of xa, ya, xb, yb equal to -1 as follows: set unplaced and leave sum, sum_1hop and max_len unchanged.
REQ-026 SHALL, in ACC for a fully placed edge, compute dx=|xa-xb| and dy=|ya-yb| in signed W-bit arithmetic, then update:
  - sum += dx+dy-1;
  - sum_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]-1;
  - max_len = max(max_len, dx+dy).
REQ-027 SHALL, in ACC, go to DONE if i==N_EDGE-1; otherwise increment i and go to FETCH_E.
REQ-028 SHALL spend exactly 5 cycles per edge. Counting the start-sample cycle as 0, ACC of edge k is in cycle 5k+5 and DONE is in cycle 5*N_EDGE+1.
REQ-029 SHALL assert done only while in DONE, then return to IDLE on the next cycle.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL hold sum, sum_1hop, max_len and unplaced stable from DONE until the next accepted start.
REQ-032 SHALL assert each read strobe for exactly one cycle per request and hold the strobes low in all other states.
REQ-033 SHALL let accumulators wrap modulo 2^W without saturation or a flag.
REQ-034 SHALL NOT write to any memory; it is read-only toward the edge ROMs and position RAMs.

Reset
REQ-035 SHALL, when reset=0, immediately (asynchronously) drive state to IDLE and all outputs to 0, including i, the captured registers and the strobes.
REQ-036 SHALL, when reset is asserted mid-evaluation, abort the run without asserting done; a new start is required after release.
REQ-037 SHALL accept start in the first cycle after reset deasserts.

Verification
REQ-038 SHALL verify: N_EDGE=3, all edges between grid-adjacent nodes (|dx|+|dy|=1) -> done in cycle 16, sum=0, sum_1hop=0, max_len=1, unplaced=0.
REQ-039 SHALL verify: N_EDGE=1, a at (0,0), b at (9,9) -> sum=17, sum_1hop=9, max_len=18.
REQ-040 SHALL verify: N_EDGE=2, edge 0 a=(2,3), b=(5,1); edge 1 with b having x=-1 -> sum=4, sum_1hop=2, max_len=5, unplaced=1.
REQ-041 SHALL verify: start re-pulsed at cycles 3 and 200 of a 96-edge run -> both ignored, single done in cycle 481, busy high in cycles 1..481.
REQ-042 SHALL verify: reset driven low in cycle 50 of a run -> outputs 0 in the same cycle, no done; a fresh start yields results identical to an uninterrupted run.
REQ-043 SHALL verify: every ea_re/px_re pulse lasts one cycle, and address sequencing matches REQ-021..REQ-023 for every edge.
